cpu_trace_capture: RTL and testbench

CPU_TRACE_CAPTURE -- requirements
Module: cpu_trace_capture

---
 rtl/cpu_trace_capture.sv | 136 +++++++++++++
 tb/tb_cpu_trace_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: captures retired-instruction records into a small FIFO and
// streams each record out as four 32-bit words over a valid/ready interface.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cap_en, retire         capture enable, one-cycle retire pulse
//   PC, Inst_code, F       retired PC, instruction word, ALU result
//   FR_ZF, FR_OF           zero / overflow flags
//   out_data, out_valid    serialized trace word and its valid
//   out_ready, out_last    sink ready, marks the final word of a record
//   ovf, drop_cnt          sticky overflow flag, saturating dropped-record count
//   clr_ovf                clears ovf and drop_cnt
//   count                  current FIFO occupancy
module cpu_trace_capture #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cap_en,
  input  logic                       retire,
  input  logic [31:0]                PC,
  input  logic [31:0]                Inst_code,
  input  logic [31:0]                F,
  input  logic                       FR_ZF,
  input  logic                       FR_OF,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       ovf,
  output logic [CNT_W-1:0]           drop_cnt,
  input  logic                       clr_ovf,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

  // Record storage; not reset, entries are discarded by clearing the pointers.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] inst_mem  [DEPTH];
  logic [31:0] f_mem     [DEPTH];
  logic [1:0]  flags_mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [1:0]       idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic push_req, push_ok, drop, hs, pop;

  always_comb begin
    out_valid = (count_q != '0);
    hs        = out_valid && out_ready;
    pop       = hs && (idx_q == 2'd3);
    push_req  = retire && cap_en;
    // A full FIFO still accepts when the head record leaves on this same edge.
    push_ok   = push_req && ((count_q < DepthC) || pop);
    drop      = push_req && !push_ok;

    out_last  = out_valid && (idx_q == 2'd3);
    out_data  = '0;
    if (out_valid) begin
      unique case (idx_q)
        2'd0: out_data = pc_mem[rd_ptr_q];
        2'd1: out_data = inst_mem[rd_ptr_q];
        2'd2: out_data = f_mem[rd_ptr_q];
        2'd3: out_data = {30'b0, flags_mem[rd_ptr_q]};
        default: out_data = '0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (hs)      idx_d    = idx_q + 2'd1;

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A drop in the clearing cycle counts as the first drop after the clear.
    if (clr_ovf) begin
      ovf_d  = drop;
      drop_d = drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q]    <= PC;
      inst_mem[wr_ptr_q]  <= Inst_code;
      f_mem[wr_ptr_q]     <= F;
      flags_mem[wr_ptr_q] <= {FR_OF, FR_ZF};
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;
  assign count    = count_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
module tb_cpu_trace_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cap_en, retire, out_ready, clr_ovf;
  logic [31:0] pc, inst, f;
  logic        zf, of;
  logic [31:0] out_data;
  logic        out_valid, out_last, ovf;
  logic [7:0]  drop_cnt;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_trace_capture #(.DEPTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_en    (cap_en),
    .retire    (retire),
    .PC        (pc),
    .Inst_code (inst),
    .F         (f),
    .FR_ZF     (zf),
    .FR_OF     (of),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input logic [31:0] p, input logic [31:0] i, input logic [31:0] r,
                         input logic o, input logic z);
    pc = p; inst = i; f = r; of = o; zf = z;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_data"},  out_data, 32'd0);
    check({tag, "_last"},  {31'b0, out_last}, 32'd0);
    check({tag, "_count"}, {28'b0, count}, 32'd0);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] w;

  initial begin
    rst_n = 1'b0; cap_en = 1'b0; retire = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    set_rec(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    check_idle("rst");
    check("rst_ovf",  {31'b0, ovf}, 32'd0);
    check("rst_drop", {24'b0, drop_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single retire, sink always ready.
    out_ready = 1'b1; cap_en = 1'b1; retire = 1'b1;
    set_rec(32'h0000_0004, 32'h0022_1820, 32'h0000_0007, 1'b1, 1'b0);
    tick();
    retire = 1'b0;
    check("s1_valid", {31'b0, out_valid}, 32'd1);
    check("s1_w0", out_data, 32'h0000_0004);
    check("s1_last0", {31'b0, out_last}, 32'd0);
    check("s1_count", {28'b0, count}, 32'd1);
    tick();
    check("s1_w1", out_data, 32'h0022_1820);
    check("s1_last1", {31'b0, out_last}, 32'd0);
    tick();
    check("s1_w2", out_data, 32'h0000_0007);
    check("s1_last2", {31'b0, out_last}, 32'd0);
    tick();
    check("s1_w3", out_data, 32'h0000_0002);
    check("s1_last3", {31'b0, out_last}, 32'd1);
    tick();
    check_idle("s1_end");

    // Retire with capture disabled: nothing stored, nothing dropped.
    cap_en = 1'b0; retire = 1'b1;
    tick();
    retire = 1'b0; cap_en = 1'b1;
    check_idle("noen");
    check("noen_ovf", {31'b0, ovf}, 32'd0);

    // Nine retires into a stalled sink: the ninth is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      retire = 1'b1;
      set_rec(32'h100 + i, 32'h200 + i, 32'h300 + i, i[1], i[0]);
      tick();
    end
    retire = 1'b0;
    check("full_count", {28'b0, count}, 32'd8);
    check("full_ovf",   {31'b0, ovf}, 32'd1);
    check("full_drop",  {24'b0, drop_cnt}, 32'd1);
    check("full_head",  out_data, 32'h100);

    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf",  {31'b0, ovf}, 32'd0);
    check("clr_drop", {24'b0, drop_cnt}, 32'd0);

    // Full FIFO, push coincident with the word-3 handshake.
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    check("co_w3",   out_data, 32'h0);
    check("co_last", {31'b0, out_last}, 32'd1);
    out_ready = 1'b1; retire = 1'b1;
    set_rec(32'h0000_0AAA, 32'h0000_0BBB, 32'h0000_0CCC, 1'b1, 1'b1);
    tick();
    retire = 1'b0; out_ready = 1'b0;
    check("co_count", {28'b0, count}, 32'd8);
    check("co_ovf",   {31'b0, ovf}, 32'd0);
    check("co_drop",  {24'b0, drop_cnt}, 32'd0);

    // Drain everything with out_ready toggling; words must hold while stalled.
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back(32'h100 + i);
      exp_q.push_back(32'h200 + i);
      exp_q.push_back(32'h300 + i);
      exp_q.push_back(32'(i % 4));
    end
    exp_q.push_back(32'h0AAA); exp_q.push_back(32'h0BBB);
    exp_q.push_back(32'h0CCC); exp_q.push_back(32'h3);
    for (int k = 0; k < 32; k++) begin
      w = exp_q[k];
      check($sformatf("dr_w%0d", k), out_data, w);
      check($sformatf("dr_l%0d", k), {31'b0, out_last}, {31'b0, (k % 4) == 3});
      out_ready = 1'b0;
      tick();
      check($sformatf("dr_hold%0d", k), out_data, w);
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check_idle("dr_end");

    // Drops with clr_ovf in the same cycle.
    for (int i = 0; i < 10; i++) begin
      retire = 1'b1;
      set_rec(32'h400 + i, 32'h500 + i, 32'h600 + i, 1'b0, 1'b0);
      tick();
    end
    retire = 1'b0;
    check("sat_drop", {24'b0, drop_cnt}, 32'd2);
    retire = 1'b1; clr_ovf = 1'b1;
    tick();
    retire = 1'b0;
    check("cd_ovf",  {31'b0, ovf}, 32'd1);
    check("cd_drop", {24'b0, drop_cnt}, 32'd1);
    tick();
    clr_ovf = 1'b0;
    check("c2_ovf",  {31'b0, ovf}, 32'd0);
    check("c2_drop", {24'b0, drop_cnt}, 32'd0);

    // Asynchronous reset while word 2 of the head record is presented.
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    check("ar_w2", out_data, 32'h600);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("ar");
    check("ar_ovf",  {31'b0, ovf}, 32'd0);
    check("ar_drop", {24'b0, drop_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1; retire = 1'b1;
    set_rec(32'h55, 32'h66, 32'h77, 1'b0, 1'b1);
    tick();
    retire = 1'b0;
    check("ar_new_w0", out_data, 32'h55);
    check("ar_new_cnt", {28'b0, count}, 32'd1);
    tick(); tick();
    check("ar_new_w2", out_data, 32'h77);
    tick();
    check("ar_new_w3", out_data, 32'h1);
    tick();
    check_idle("ar_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
